cmp_rs_pipe: RTL and testbench
==============================

// Module: cmp_rs_pipe
// PURPOSE
//  Multi-channel branch-compare execution unit between the compare reservation-station entries and the common data bus (CDB).
//  Each channel accepts one compare op (r1, r2, opcode, ROB tag) via valid/ready and registers the result in a per-channel slot.
//  A round-robin arbiter drains one slot per cycle onto a single CDB port with valid/ready backpressure.
//  A synchronous flush squashes all in-flight results on a mispredict.
// PARAMETERS
//  CHANNELS  8   number of input channels (RS entries), >=2
//  DATA_W    32  operand width
//  TAG_W     4   ROB tag width
//  CH_W      $clog2(CHANNELS)  local param, channel index width
// PORTS
//  clk         in   1               clock, all state updates on rising edge
//  rst_n       in   1               asynchronous active-low reset
//  flush       in   1               sync squash of all slots/lock
//  in_valid    in   CHANNELS        per-channel op valid
//  in_ready    out  CHANNELS        per-channel op accept
//  in_r1       in   [CHANNELS][DATA_W]  operand 1
//  in_r2       in   [CHANNELS][DATA_W]  operand 2
//  in_op       in   [CHANNELS][3]   funct3: 000 beq,001 bne,100 blt,101 bge,110 bltu,111 bgeu
//  in_tag      in   [CHANNELS][TAG_W]  ROB tag
//  out_valid   out  1               CDB result valid
//  out_ready   in   1               CDB accepts result
//  out_tag     out  TAG_W           tag of granted result
//  out_taken   out  1               compare outcome (1 = condition true)
//  out_chan    out  CH_W            channel index of granted result
// BEHAVIOUR
//  - Reset (async, rst_n=0): slot_v all 0, slot tag/taken 0, rr_ptr 0, lock 0; out_valid 0, out_tag 0, out_taken 0, out_chan 0; in_ready all 1.
//  - Accept ch i when in_valid[i]&&in_ready[i]: taken computed from r1/r2/op, stored with tag in slot i, slot_v[i]<=1 next edge.
//  - Compare: blt/bge signed DATA_W, bltu/bgeu unsigned; bge = !(blt), bgeu = !(bltu). Opcodes 010/011: taken=0, op still completes.
//  - in_ready[i] = !flush && (!slot_v[i] || (out_valid && out_ready && out_chan==i)): full slot reloads same cycle it drains.
//  - Latency: accepted at edge N -> out_valid earliest in cycle after edge N (1 cycle). Throughput 1 result/cycle total.
//  - Arbiter: when lock=0, grant = first i with slot_v[i], searching rr_ptr, rr_ptr+1, ... mod CHANNELS. out_valid = |slot_v && !flush.
//  - Handshake (out_valid&&out_ready): slot_v[grant]<=0 (unless reloaded same edge), rr_ptr<=(grant+1) mod CHANNELS, lock<=0.
//  - Stall (out_valid&&!out_ready): lock<=1, locked_ch<=grant; while lock=1 grant=locked_ch. out_tag/out_taken/out_chan stable until accepted.
//  - rr_ptr unchanged when no handshake; wraps CHANNELS-1 -> 0.
//  - flush=1: in_ready all 0, out_valid 0, next edge slot_v all 0, lock 0; rr_ptr held. in_valid/out_ready ignored that cycle.
//  - Reset mid-stall: all state cleared immediately, out_valid drops asynchronously.
// CONFIGURATION
//  CMP_PERF_EN defined: adds outputs perf_done[31:0] (count of CDB handshakes) and perf_stall[31:0] (cycles out_valid&&!out_ready).
//   Both saturate at 32'hFFFF_FFFF, reset to 0 by rst_n, unaffected by flush.
//  CMP_PERF_EN undefined: ports and counters absent, no other change.
// TESTING
//  1. ch0 r1=5 r2=5 op=000 tag=3, out_ready=1 -> one cycle later out_valid=1 tag=3 taken=1 chan=0; in_ready[0] stays 1.
//  2. ch2 r1=32'hFFFF_FFFF r2=1: op=100 -> taken=1; op=110 -> taken=0; op=111 -> taken=1; op=011 -> taken=0.
//  3. All 8 ch valid same cycle, out_ready=1 -> 8 results over 8 consecutive cycles chan 0..7; next batch starts at chan 0.
//  4. out_ready=0 for 4 cycles with ch5 pending, ch1 arrives mid-stall -> out_chan=5, tag/taken stable; ch5 drains first, then ch1.
//  5. 3 slots valid, flush=1 one cycle -> out_valid=0 that cycle and next; in_ready all 1 after; no stale tags on CDB.
//  6. rst_n low during stall -> out_valid=0 immediately; with CMP_PERF_EN, after 10 handshakes + 3 stalls perf_done=10 perf_stall=3.

Source files
------------

// File: rtl/cmp_rs_pipe.sv
// Multi-channel branch-compare unit: per-channel result slots drained round-robin onto one CDB port.
// Optional CMP_PERF_EN adds saturating handshake/stall counters (o_perf_done, o_perf_stall).
module cmp_rs_pipe #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic [CHANNELS-1:0]           i_in_valid,
    output logic [CHANNELS-1:0]           o_in_ready,
    input  logic [CHANNELS*DATA_W-1:0]    i_in_r1,
    input  logic [CHANNELS*DATA_W-1:0]    i_in_r2,
    input  logic [CHANNELS*3-1:0]         i_in_op,
    input  logic [CHANNELS*TAG_W-1:0]     i_in_tag,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [TAG_W-1:0]              o_out_tag,
    output logic                          o_out_taken,
    output logic [$clog2(CHANNELS)-1:0]   o_out_chan
`ifdef CMP_PERF_EN
    ,
    output logic [31:0]                   o_perf_done,
    output logic [31:0]                   o_perf_stall
`endif
);

    localparam int unsigned CH_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0] r_slot_v;
    logic [CHANNELS-1:0] r_slot_taken;
    logic [TAG_W-1:0]    r_slot_tag [CHANNELS];
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_locked_ch;
    logic                r_lock;

    logic [CH_W-1:0]     w_grant;
    logic [CH_W-1:0]     w_idx;
    logic                w_found;
    logic                w_hs;
    logic [CHANNELS-1:0] w_accept;
    logic [CHANNELS-1:0] w_taken;

    function automatic logic f_taken(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                     input logic [2:0] op);
        logic res;
        case (op)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) < $signed(b));
            3'b101:  res = !($signed(a) < $signed(b));
            3'b110:  res = (a < b);
            3'b111:  res = !(a < b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // A stalled grant stays locked so the CDB payload cannot change before it is taken.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_lock) begin
            w_grant = r_locked_ch;
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                w_idx = CH_W'((32'(r_rr_ptr) + 32'(k)) % CHANNELS);
                if (!w_found && r_slot_v[w_idx]) begin
                    w_grant = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign o_out_valid = (|r_slot_v) && !i_flush;
    assign w_hs        = o_out_valid && i_out_ready;
    assign o_out_tag   = r_slot_tag[w_grant];
    assign o_out_taken = r_slot_taken[w_grant];
    assign o_out_chan  = w_grant;

    // A full slot can take a new op in the same cycle its result is handed to the CDB.
    always_comb begin
        o_in_ready = '0;
        w_accept   = '0;
        w_taken    = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            o_in_ready[i] = !i_flush && (!r_slot_v[i] || (w_hs && (w_grant == CH_W'(i))));
            w_accept[i]   = i_in_valid[i] && o_in_ready[i];
            w_taken[i]    = f_taken(i_in_r1[i*DATA_W +: DATA_W], i_in_r2[i*DATA_W +: DATA_W],
                                    i_in_op[i*3 +: 3]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_v     <= '0;
            r_slot_taken <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_slot_tag[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_locked_ch <= '0;
            r_lock      <= 1'b0;
        end else if (i_flush) begin
            r_slot_v <= '0;
            r_lock   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (w_accept[i]) begin
                    r_slot_v[i]     <= 1'b1;
                    r_slot_taken[i] <= w_taken[i];
                    r_slot_tag[i]   <= i_in_tag[i*TAG_W +: TAG_W];
                end else if (w_hs && (w_grant == CH_W'(i))) begin
                    r_slot_v[i] <= 1'b0;
                end
            end
            if (w_hs) begin
                r_rr_ptr <= (w_grant == CH_W'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
                r_lock   <= 1'b0;
            end else if (o_out_valid) begin
                r_lock      <= 1'b1;
                r_locked_ch <= w_grant;
            end
        end
    end

`ifdef CMP_PERF_EN
    logic [31:0] r_perf_done;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_done  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_hs && (r_perf_done != 32'hFFFF_FFFF)) begin
                r_perf_done <= r_perf_done + 32'd1;
            end
            if (o_out_valid && !i_out_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_done  = r_perf_done;
    assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_cmp_rs_pipe.sv
// Scoreboard bench for cmp_rs_pipe: directed ops push expected CDB results, a monitor pops and compares.
module tb_cmp_rs_pipe;

    localparam int CH = 8;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [CH*DW-1:0]  in_r1 = '0;
    logic [CH*DW-1:0]  in_r2 = '0;
    logic [CH*3-1:0]   in_op = '0;
    logic [CH*TW-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [TW-1:0]     out_tag;
    logic              out_taken;
    logic [CW-1:0]     out_chan;
`ifdef CMP_PERF_EN
    logic [31:0]       perf_done;
    logic [31:0]       perf_stall;
`endif

    cmp_rs_pipe #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .TAG_W    (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_r1     (in_r1),
        .i_in_r2     (in_r2),
        .i_in_op     (in_op),
        .i_in_tag    (in_tag),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_tag   (out_tag),
        .o_out_taken (out_taken),
        .o_out_chan  (out_chan)
`ifdef CMP_PERF_EN
        ,
        .o_perf_done (perf_done),
        .o_perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          taken;
        logic [CW-1:0] chan;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [2:0] t2_op  [7] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b000, 3'b001, 3'b101};
    logic       t2_exp [7] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0};

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops on every CDB handshake and checks payload stability across stall cycles.
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_tag;
    logic          prev_taken;
    logic [CW-1:0] prev_chan;
    exp_t          e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_tag_stable", 32'(out_tag), 32'(prev_tag));
                chk("stall_taken_stable", 32'(out_taken), 32'(prev_taken));
                chk("stall_chan_stable", 32'(out_chan), 32'(prev_chan));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got tag 0x%0h chan %0d, expected no result",
                             out_tag, out_chan);
                end else begin
                    e = q.pop_front();
                    chk("cdb_tag", 32'(out_tag), 32'(e.tag));
                    chk("cdb_taken", 32'(out_taken), 32'(e.taken));
                    chk("cdb_chan", 32'(out_chan), 32'(e.chan));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_tag   = out_tag;
            prev_taken = out_taken;
            prev_chan  = out_chan;
        end
    end

    task automatic set_op(input int ch, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [3:0] tag);
        in_valid[ch]          = 1'b1;
        in_r1[ch*DW +: DW]    = a;
        in_r2[ch*DW +: DW]    = b;
        in_op[ch*3 +: 3]      = op;
        in_tag[ch*TW +: TW]   = tag;
    endtask

    task automatic expect_res(input logic [3:0] tag, input logic taken, input int ch);
        exp_t x;
        x.tag   = tag;
        x.taken = taken;
        x.chan  = CW'(ch);
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic send(input int ch, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [3:0] tag, input logic taken);
        set_op(ch, a, b, op, tag);
        expect_res(tag, taken, ch);
        step();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: got %0d results pending, expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_taken", 32'(out_taken), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: beq equal, one-cycle latency, ch0 stays ready while draining
        set_op(0, 32'd5, 32'd5, 3'b000, 4'd3);
        expect_res(4'd3, 1'b1, 0);
        step();
        @(negedge clk);
        chk("t1_latency_valid", 32'(out_valid), 32'd1);
        chk("t1_in_ready0", 32'(in_ready[0]), 32'd1);
        wait_drain("t1");

        // 2: signed/unsigned compares on -1 vs 1, back to back on ch2
        for (int i = 0; i < 7; i++) begin
            send(2, 32'hFFFF_FFFF, 32'd1, t2_op[i], 4'(i + 1), t2_exp[i]);
        end
        wait_drain("t2");
        send(7, 32'd3, 32'd7, 3'b110, 4'h9, 1'b1);
        wait_drain("t2b");

        // 3: all channels at once, two batches, each drains 0..7 back to back
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < CH; i++) begin
                set_op(i, 32'(i), 32'd3, (b == 0) ? 3'b100 : 3'b101, 4'(i + 8 * (1 - b)));
                expect_res(4'(i + 8 * (1 - b)), (b == 0) ? (i < 3) : (i >= 3), i);
            end
            step();
            for (int i = 0; i < CH; i++) begin
                @(negedge clk);
                chk($sformatf("t3_b%0d_valid_%0d", b, i), 32'(out_valid), 32'd1);
            end
            @(negedge clk);
            chk($sformatf("t3_b%0d_idle", b), 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            wait_drain("t3");
        end

        // 4: stall on ch5, ch1 arrives mid-stall, ch5 must go first
        out_ready = 1'b0;
        send(5, 32'hFFFF_FFFE, 32'd1, 3'b100, 4'd5, 1'b1);
        send(1, 32'd10, 32'd10, 3'b001, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall_chan", 32'(out_chan), 32'd5);
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("t4");

        // 5: flush with three slots full; inputs and out_ready ignored that cycle
        out_ready = 1'b0;
        set_op(0, 32'd1, 32'd1, 3'b000, 4'hA);
        set_op(3, 32'd1, 32'd2, 3'b000, 4'hB);
        set_op(6, 32'd1, 32'd2, 3'b001, 4'hC);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        set_op(1, 32'd0, 32'd0, 3'b000, 4'hD);
        @(negedge clk);
        chk("t5_flush_valid", 32'(out_valid), 32'd0);
        chk("t5_flush_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = '0;
        @(negedge clk);
        chk("t5_post_valid", 32'(out_valid), 32'd0);
        chk("t5_post_ready", 32'(in_ready), 32'hFF);
        @(posedge clk);
        #1;
        send(4, 32'd0, 32'd0, 3'b000, 4'hE, 1'b1);
        wait_drain("t5");

        // 6: async reset during a stall
        out_ready = 1'b0;
        set_op(2, 32'd1, 32'd1, 3'b000, 4'd7);
        step();
        @(negedge clk);
        chk("t6_stall_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_tag", 32'(out_tag), 32'd0);
        chk("t6_rst_chan", 32'(out_chan), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 3 stall cycles then 10 handshakes
        set_op(0, 32'd1, 32'd2, 3'b110, 4'd0);
        expect_res(4'd0, 1'b1, 0);
        step();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 1; k < 10; k++) begin
            send(k % CH, 32'(k), 32'd5, 3'b111, 4'(k), k >= 5);
        end
        wait_drain("t6");
`ifdef CMP_PERF_EN
        chk("perf_done", perf_done, 32'd10);
        chk("perf_stall", perf_stall, 32'd3);
`endif
        @(negedge clk);
        chk("end_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
